// File: rtl/msi_l1_ctrl.sv
// msi_l1_ctrl -- fully-associative L1 cache controller with MSI coherence.
//
// Line states: I=01, S=10, M=11 (00 never stored).
// Controller FSM: IDLE -> (RESP | WB | MISS); WB -> MISS -> WAIT -> RESP -> IDLE.
//
// Ports
//   Clock, Resetn          : rising-edge clock, synchronous active-low reset
//   ReqValid/ReqReady      : processor request handshake
//   ReqWrite/ReqAddr/ReqData: request kind (1=write), address, write data
//   RespValid/RespHit/RespData : one-cycle processor response
//   DirValid/DirReady      : directory request handshake
//   DirType/DirAddr/DirData: 01 ReadMiss, 10 WriteMiss, 11 WriteBack
//   FillValid/FillData     : directory fill, honoured only in WAIT
//   SnpValid/SnpType/SnpAddr : snoop (01 Inv, 10 Fetch, 11 FetchInv)
//   SnpAck/SnpHit/SnpData  : one-cycle snoop response
module msi_l1_ctrl #(
  parameter int LINES = 4,
  parameter int AW    = 4,
  parameter int DW    = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] ReqData,
  output logic          RespValid,
  output logic          RespHit,
  output logic [DW-1:0] RespData,
  output logic          DirValid,
  input  logic          DirReady,
  output logic [1:0]    DirType,
  output logic [AW-1:0] DirAddr,
  output logic [DW-1:0] DirData,
  input  logic          FillValid,
  input  logic [DW-1:0] FillData,
  input  logic          SnpValid,
  input  logic [1:0]    SnpType,
  input  logic [AW-1:0] SnpAddr,
  output logic          SnpAck,
  output logic          SnpHit,
  output logic [DW-1:0] SnpData
);

  localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [1:0] ST_I = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic [2:0] {IDLE, WB, MISS, WAIT, RESP} state_t;

  state_t          state_q, state_nxt;
  logic [AW-1:0]   tag_q  [LINES];
  logic [DW-1:0]   data_q [LINES];
  logic [1:0]      st_q   [LINES];
  logic [IW-1:0]   vptr_q;
  logic [IW-1:0]   victim_q;
  logic            req_write_q;
  logic [AW-1:0]   req_addr_q;
  logic [DW-1:0]   req_data_q;
  logic            resp_hit_q;
  logic [DW-1:0]   resp_data_q;
  logic            snp_ack_q;
  logic            snp_hit_q;
  logic [DW-1:0]   snp_data_q;
  // run_q holds ReqReady low for the first cycle after reset release
  logic            run_q;
  // dir_gap_q forces a DirValid-low cycle between WriteBack and the miss request
  logic            dir_gap_q;

  logic            accept;
  logic            dir_fire;
  logic            snp_ok;
  logic            fill_ok;
  logic            req_hit;
  logic [IW-1:0]   req_idx;
  logic            snp_match;
  logic [IW-1:0]   snp_idx;
  logic            inv_tag_found;
  logic [IW-1:0]   inv_tag_idx;
  logic            inv_found;
  logic [IW-1:0]   inv_idx;
  logic [IW-1:0]   victim_c;
  logic            use_vptr;

  // Tag lookups and victim choice; descending scan so the lowest index wins.
  always_comb begin
    req_hit       = 1'b0;
    req_idx       = '0;
    snp_match     = 1'b0;
    snp_idx       = '0;
    inv_tag_found = 1'b0;
    inv_tag_idx   = '0;
    inv_found     = 1'b0;
    inv_idx       = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (st_q[i] != ST_I && tag_q[i] == ReqAddr) begin
        req_hit = 1'b1;
        req_idx = IW'(i);
      end
      if (st_q[i] != ST_I && tag_q[i] == SnpAddr) begin
        snp_match = 1'b1;
        snp_idx   = IW'(i);
      end
      if (st_q[i] == ST_I && tag_q[i] == ReqAddr) begin
        inv_tag_found = 1'b1;
        inv_tag_idx   = IW'(i);
      end
      if (st_q[i] == ST_I) begin
        inv_found = 1'b1;
        inv_idx   = IW'(i);
      end
    end
    use_vptr = 1'b0;
    if (req_hit) begin
      victim_c = req_idx;
    end else if (inv_tag_found) begin
      victim_c = inv_tag_idx;
    end else if (inv_found) begin
      victim_c = inv_idx;
    end else begin
      victim_c = vptr_q;
      use_vptr = 1'b1;
    end
  end

  assign snp_ok  = SnpValid && !snp_ack_q &&
                   (state_q == IDLE || state_q == WAIT || state_q == RESP);
  assign fill_ok = (state_q == WAIT) && FillValid;

  assign SnpAck  = snp_ack_q;
  assign SnpHit  = snp_ack_q & snp_hit_q;
  assign SnpData = snp_data_q;

  always_comb begin
    state_nxt = state_q;
    ReqReady  = 1'b0;
    accept    = 1'b0;
    DirValid  = 1'b0;
    DirType   = 2'b00;
    DirAddr   = '0;
    DirData   = '0;
    dir_fire  = 1'b0;
    RespValid = 1'b0;
    RespHit   = 1'b0;
    RespData  = '0;

    ReqReady = run_q && (state_q == IDLE) && !SnpValid;
    accept   = ReqValid && ReqReady;

    if ((state_q == WB || state_q == MISS) && !dir_gap_q) begin
      DirValid = 1'b1;
      if (state_q == WB) begin
        DirType = 2'b11;
        DirAddr = tag_q[victim_q];
        DirData = data_q[victim_q];
      end else begin
        DirType = req_write_q ? 2'b10 : 2'b01;
        DirAddr = req_addr_q;
      end
    end
    dir_fire = DirValid && DirReady;

    if (state_q == RESP) begin
      RespValid = 1'b1;
      RespHit   = resp_hit_q;
      RespData  = resp_data_q;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_hit && (!ReqWrite || st_q[req_idx] == ST_M)) begin
            state_nxt = RESP;
          end else if (!req_hit && st_q[victim_c] == ST_M) begin
            state_nxt = WB;
          end else begin
            state_nxt = MISS;
          end
        end
      end
      WB:      if (dir_fire) state_nxt = MISS;
      MISS:    if (dir_fire) state_nxt = WAIT;
      WAIT:    if (FillValid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      dir_gap_q   <= 1'b0;
      vptr_q      <= '0;
      victim_q    <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      resp_hit_q  <= 1'b0;
      resp_data_q <= '0;
      snp_ack_q   <= 1'b0;
      snp_hit_q   <= 1'b0;
      snp_data_q  <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        st_q[i]   <= ST_I;
      end
    end else begin
      state_q    <= state_nxt;
      run_q      <= 1'b1;
      dir_gap_q  <= (state_q == WB) && dir_fire;
      snp_ack_q  <= 1'b0;
      snp_hit_q  <= 1'b0;
      snp_data_q <= '0;

      // Snoop sees pre-fill contents; a same-edge fill below overrides it.
      if (snp_ok) begin
        snp_ack_q <= 1'b1;
        snp_hit_q <= snp_match;
        if (snp_match) begin
          case (SnpType)
            2'b01: st_q[snp_idx] <= ST_I;
            2'b10: begin
              if (st_q[snp_idx] == ST_M) begin
                snp_data_q     <= data_q[snp_idx];
                st_q[snp_idx]  <= ST_S;
              end
            end
            2'b11: begin
              if (st_q[snp_idx] == ST_M) snp_data_q <= data_q[snp_idx];
              st_q[snp_idx] <= ST_I;
            end
            default: ;
          endcase
        end
      end

      if (accept) begin
        req_write_q <= ReqWrite;
        req_addr_q  <= ReqAddr;
        req_data_q  <= ReqData;
        victim_q    <= victim_c;
        if (use_vptr) vptr_q <= vptr_q + 1'b1;
        if (req_hit && !ReqWrite) begin
          resp_hit_q  <= 1'b1;
          resp_data_q <= data_q[req_idx];
        end else if (req_hit && st_q[req_idx] == ST_M) begin
          resp_hit_q      <= 1'b1;
          resp_data_q     <= ReqData;
          data_q[req_idx] <= ReqData;
        end
      end

      if ((state_q == WB) && dir_fire) st_q[victim_q] <= ST_I;

      if (fill_ok) begin
        tag_q[victim_q]  <= req_addr_q;
        data_q[victim_q] <= req_write_q ? req_data_q : FillData;
        st_q[victim_q]   <= req_write_q ? ST_M : ST_S;
        resp_data_q      <= req_write_q ? req_data_q : FillData;
        resp_hit_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msi_l1_ctrl.sv
// tb_msi_l1_ctrl -- directed and randomized bench for msi_l1_ctrl against a
// line-array reference model (LINES=4, AW=4, DW=4).
module tb_msi_l1_ctrl;

  localparam int LINES = 4;
  localparam int I = 1, S = 2, M = 3;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [3:0] ReqAddr = '0, ReqData = '0;
  logic       ReqReady;
  logic       RespValid, RespHit;
  logic [3:0] RespData;
  logic       DirValid;
  logic       DirReady = 1'b0;
  logic [1:0] DirType;
  logic [3:0] DirAddr, DirData;
  logic       FillValid = 1'b0;
  logic [3:0] FillData = '0;
  logic       SnpValid = 1'b0;
  logic [1:0] SnpType = '0;
  logic [3:0] SnpAddr = '0;
  logic       SnpAck, SnpHit;
  logic [3:0] SnpData;

  always #5 Clock = ~Clock;

  msi_l1_ctrl #(.LINES(LINES), .AW(4), .DW(4)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespHit(RespHit), .RespData(RespData),
    .DirValid(DirValid), .DirReady(DirReady), .DirType(DirType),
    .DirAddr(DirAddr), .DirData(DirData),
    .FillValid(FillValid), .FillData(FillData),
    .SnpValid(SnpValid), .SnpType(SnpType), .SnpAddr(SnpAddr),
    .SnpAck(SnpAck), .SnpHit(SnpHit), .SnpData(SnpData)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-line state/tag/data plus the replacement pointer.
  int         m_st   [LINES];
  logic [3:0] m_tag  [LINES];
  logic [3:0] m_data [LINES];
  int         m_vptr;

  task automatic m_reset();
    for (int i = 0; i < LINES; i++) begin
      m_st[i] = I; m_tag[i] = '0; m_data[i] = '0;
    end
    m_vptr = 0;
  endtask

  function automatic int m_find(input logic [3:0] a);
    for (int i = 0; i < LINES; i++)
      if (m_st[i] != I && m_tag[i] == a) return i;
    return -1;
  endfunction

  task automatic m_victim(input logic [3:0] a, output int v);
    for (int i = 0; i < LINES; i++)
      if (m_st[i] == I && m_tag[i] == a) begin v = i; return; end
    for (int i = 0; i < LINES; i++)
      if (m_st[i] == I) begin v = i; return; end
    v = m_vptr;
    m_vptr = (m_vptr + 1) % LINES;
  endtask

  task automatic model_snp(input logic [1:0] t, input logic [3:0] a,
                           output logic eh, output logic [3:0] ed);
    int h;
    h = m_find(a);
    eh = (h >= 0);
    ed = '0;
    if (h >= 0) begin
      case (t)
        2'd1: m_st[h] = I;
        2'd2: if (m_st[h] == M) begin ed = m_data[h]; m_st[h] = S; end
        2'd3: begin if (m_st[h] == M) ed = m_data[h]; m_st[h] = I; end
        default: ;
      endcase
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  32'(ReqReady), 32'd0);
    chk({tag, "_resp"}, 32'({RespValid, RespHit, RespData}), 32'd0);
    chk({tag, "_dir"},  32'({DirValid, DirType, DirAddr, DirData}), 32'd0);
    chk({tag, "_snp"},  32'({SnpAck, SnpHit, SnpData}), 32'd0);
  endtask

  // Waits for DirValid, checks fields and stability, then completes the handshake.
  task automatic dir_hs(input string tag, input logic [1:0] typ, input logic [3:0] addr,
                        input logic [3:0] data, input bit chk_data);
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (DirValid === 1'b1) break;
    end
    chk({tag, "_vld"}, 32'(DirValid), 32'd1);
    if (DirValid !== 1'b1) return;
    chk({tag, "_type"}, 32'(DirType), 32'(typ));
    chk({tag, "_addr"}, 32'(DirAddr), 32'(addr));
    if (chk_data) chk({tag, "_data"}, 32'(DirData), 32'(data));
    repeat ($urandom_range(0, 2)) begin
      @(negedge Clock);
      chk({tag, "_hold"}, 32'({DirValid, DirType, DirAddr}), 32'({1'b1, typ, addr}));
    end
    DirReady = 1'b1;
    @(posedge Clock); #1;
    DirReady = 1'b0;
    @(negedge Clock);
    chk({tag, "_drop"}, 32'(DirValid), 32'd0);
  endtask

  task automatic req_accept(input logic w, input logic [3:0] a, input logic [3:0] d);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqData = d;
    for (int c = 0; c < 60 && ReqReady !== 1'b1; c++) begin
      @(negedge Clock); #1;
    end
    chk("req_ready", 32'(ReqReady), 32'd1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
  endtask

  // Runs a miss through optional WriteBack and the miss request; returns victim.
  task automatic req_to_wait(input logic w, input logic [3:0] a, output int v);
    int h;
    h = m_find(a);
    if (h >= 0) v = h;
    else m_victim(a, v);
    if (m_st[v] == M) begin
      dir_hs("wb", 2'b11, m_tag[v], m_data[v], 1'b1);
      m_st[v] = I;
    end
    dir_hs("miss", w ? 2'b10 : 2'b01, a, 4'd0, 1'b0);
  endtask

  // fd < 0 picks a random fill value; snp_fill drives a snoop on the fill cycle.
  task automatic req_finish(input logic w, input logic [3:0] a, input logic [3:0] d,
                            input int fd, input bit snp_fill,
                            input logic [1:0] st, input logic [3:0] sa);
    int h, v;
    logic [3:0] exp_d, fdv, ed;
    logic eh;
    h = m_find(a);
    if (h >= 0 && (!w || m_st[h] == M)) begin
      exp_d = w ? d : m_data[h];
      if (w) m_data[h] = d;
      @(negedge Clock);
      chk("hit_vld",  32'(RespValid), 32'd1);
      chk("hit_hit",  32'(RespHit),   32'd1);
      chk("hit_data", 32'(RespData),  32'(exp_d));
      chk("hit_nodir", 32'(DirValid), 32'd0);
    end else begin
      req_to_wait(w, a, v);
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      fdv = (fd < 0) ? 4'($urandom) : 4'(fd);
      FillValid = 1'b1; FillData = fdv;
      eh = 1'b0; ed = '0;
      if (snp_fill) begin
        model_snp(st, sa, eh, ed);
        SnpValid = 1'b1; SnpType = st; SnpAddr = sa;
      end
      @(posedge Clock); #1;
      FillValid = 1'b0;
      @(negedge Clock);
      exp_d = w ? d : fdv;
      chk("fill_vld",  32'(RespValid), 32'd1);
      chk("fill_hit",  32'(RespHit),   32'd0);
      chk("fill_data", 32'(RespData),  32'(exp_d));
      if (snp_fill) begin
        chk("wsnp_ack",  32'(SnpAck),  32'd1);
        chk("wsnp_hit",  32'(SnpHit),  32'(eh));
        chk("wsnp_data", 32'(SnpData), 32'(ed));
        SnpValid = 1'b0;
      end
      m_tag[v] = a; m_data[v] = exp_d; m_st[v] = w ? M : S;
    end
    @(negedge Clock);
    chk("resp_1cyc", 32'(RespValid), 32'd0);
  endtask

  task automatic do_req(input logic w, input logic [3:0] a, input logic [3:0] d, input int fd);
    req_accept(w, a, d);
    req_finish(w, a, d, fd, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic do_snp(input logic [1:0] t, input logic [3:0] a);
    logic eh;
    logic [3:0] ed;
    model_snp(t, a, eh, ed);
    SnpValid = 1'b1; SnpType = t; SnpAddr = a;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (SnpAck === 1'b1) break;
    end
    chk("snp_ack",  32'(SnpAck),  32'd1);
    chk("snp_hit",  32'(SnpHit),  32'(eh));
    chk("snp_data", 32'(SnpData), 32'(ed));
    SnpValid = 1'b0;
    @(negedge Clock);
    chk("snp_1cyc", 32'({SnpAck, SnpHit, SnpData}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic eh;
    logic [3:0] ed;
    int v;
    m_reset();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk_zero("reset");
    Resetn = 1'b1;

    // Read miss, refill, hit, upgrade and fetch snoop on address 3.
    do_req(1'b0, 4'd3, 4'd0, 9);
    do_req(1'b0, 4'd3, 4'd0, -1);
    do_req(1'b1, 4'd3, 4'd5, -1);
    do_snp(2'd2, 4'd3);
    do_req(1'b0, 4'd3, 4'd0, -1);

    // Four M lines, then two evictions through the round-robin pointer.
    do_req(1'b1, 4'd4, 4'd1, -1);
    do_req(1'b1, 4'd5, 4'd2, -1);
    do_req(1'b1, 4'd6, 4'd4, -1);
    do_req(1'b1, 4'd3, 4'd7, -1);
    do_req(1'b0, 4'd7, 4'd0, -1);
    do_req(1'b0, 4'd8, 4'd0, -1);

    // Snoop and request presented together: snoop wins, request next cycle.
    @(negedge Clock);
    SnpValid = 1'b1; SnpType = 2'd1; SnpAddr = 4'd5;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'd6; ReqData = 4'd0;
    #1;
    chk("prio_rdy0", 32'(ReqReady), 32'd0);
    model_snp(2'd1, 4'd5, eh, ed);
    @(posedge Clock);
    @(negedge Clock);
    chk("prio_ack", 32'(SnpAck), 32'd1);
    chk("prio_hit", 32'(SnpHit), 32'(eh));
    SnpValid = 1'b0;
    #1;
    chk("prio_rdy1", 32'(ReqReady), 32'd1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    req_finish(1'b0, 4'd6, 4'd0, -1, 1'b0, 2'd0, 4'd0);

    // Upgrade with an invalidate of the same line arriving with the fill.
    req_accept(1'b1, 4'd7, 4'd11);
    req_finish(1'b1, 4'd7, 4'd11, -1, 1'b1, 2'd1, 4'd7);
    do_req(1'b0, 4'd7, 4'd0, -1);
    // Miss with a FetchInvalidate of another M line alongside the fill.
    req_accept(1'b0, 4'd9, 4'd0);
    req_finish(1'b0, 4'd9, 4'd0, -1, 1'b1, 2'd3, 4'd6);

    // Randomized traffic: requests, idle snoops, stray fills.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic w;
      logic [3:0] a, d, sa;
      logic [1:0] st;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        do_snp(2'($urandom_range(1, 3)), 4'($urandom_range(0, 7)));
      end else if (r == 2) begin
        FillValid = 1'b1; FillData = 4'($urandom);
        @(posedge Clock); #1;
        FillValid = 1'b0;
        @(negedge Clock);
        chk("stray_fill", 32'(RespValid), 32'd0);
      end else begin
        w  = 1'($urandom);
        a  = 4'($urandom_range(0, 7));
        d  = 4'($urandom);
        st = 2'($urandom_range(1, 3));
        sa = 4'($urandom_range(0, 7));
        req_accept(w, a, d);
        req_finish(w, a, d, -1, ($urandom_range(0, 3) == 0), st, sa);
      end
    end

    // Reset while waiting for a fill; the late fill must be ignored.
    req_accept(1'b0, 4'd12, 4'd0);
    req_to_wait(1'b0, 4'd12, v);
    Resetn = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk_zero("rst_wait");
    Resetn = 1'b1;
    FillValid = 1'b1; FillData = 4'd9;
    @(posedge Clock); #1;
    FillValid = 1'b0;
    m_reset();
    @(negedge Clock);
    chk("late_fill", 32'(RespValid), 32'd0);
    do_req(1'b0, 4'd12, 4'd0, -1);
    do_req(1'b0, 4'd12, 4'd0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
